multicycle_controller: RTL and testbench

//  Moore FSM main controller for the multicycle MIPS datapath; successor to the single-cycle main decoder.

---
 rtl/multicycle_controller.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main controller for the multicycle MIPS datapath.
// Moore FSM sequencing fetch/decode/execute/memory/writeback, with a memory
// ready/wait handshake and illegal-opcode detection.
// Optional feature: define BNE_EN to accept bne (opcode 000101) and add the
// branch_ne output; without it, 000101 is reported as illegal.
module multicycle_controller #(
    parameter int unsigned OP_WIDTH      = 6,
    parameter int unsigned ALUOP_WIDTH   = 2,
    parameter int unsigned MEM_HANDSHAKE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [OP_WIDTH-1:0]    op,
    input  logic                   mem_ready,
    output logic                   iord,
    output logic                   alusrca,
    output logic [1:0]             alusrcb,
    output logic [ALUOP_WIDTH-1:0] aluop,
    output logic [1:0]             pcsrc,
    output logic                   irwrite,
    output logic                   pcwrite,
    output logic                   branch,
    output logic                   memwrite,
    output logic                   regwrite,
    output logic                   regdst,
    output logic                   memtoreg,
    output logic                   illegal_op,
`ifdef BNE_EN
    output logic                   branch_ne,
`endif
    output logic [3:0]             state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(6'b000000);
    localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'b100011);
    localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'b101011);
    localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'b000100);
    localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'b001000);
    localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'b000010);
`ifdef BNE_EN
    localparam logic [OP_WIDTH-1:0] OP_BNE  = OP_WIDTH'(6'b000101);
`endif

    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = ALUOP_WIDTH'(2'b00);
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUB   = ALUOP_WIDTH'(2'b01);
    localparam logic [ALUOP_WIDTH-1:0] ALU_FUNCT = ALUOP_WIDTH'(2'b10);

    state_t cur;
    logic   mem_ok;
    logic   is_r, is_lw, is_sw, is_beq, is_addi, is_j, is_bne, op_known;

    // Memory completion: ignored when the handshake is compiled out
    assign mem_ok = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    // Opcode classification from the instruction register
    always_comb begin
        is_r    = (op == OP_R);
        is_lw   = (op == OP_LW);
        is_sw   = (op == OP_SW);
        is_beq  = (op == OP_BEQ);
        is_addi = (op == OP_ADDI);
        is_j    = (op == OP_J);
`ifdef BNE_EN
        is_bne  = (op == OP_BNE);
`else
        is_bne  = 1'b0;
`endif
        op_known = is_r | is_lw | is_sw | is_beq | is_addi | is_j | is_bne;
    end

    // State register and next-state sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= S_FETCH;
        end else begin
            case (cur)
                S_FETCH:   cur <= mem_ok ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    if (is_r)                 cur <= S_EXECUTE;
                    else if (is_lw || is_sw)  cur <= S_MEMADR;
                    else if (is_beq || is_bne) cur <= S_BRANCH;
                    else if (is_addi)         cur <= S_ADDIEX;
                    else if (is_j)            cur <= S_JUMP;
                    else                      cur <= S_FETCH;
                end
                S_MEMADR:  cur <= is_lw ? S_MEMRD : S_MEMWR;
                S_MEMRD:   cur <= mem_ok ? S_MEMWB : S_MEMRD;
                S_MEMWB:   cur <= S_FETCH;
                S_MEMWR:   cur <= mem_ok ? S_FETCH : S_MEMWR;
                S_EXECUTE: cur <= S_ALUWB;
                S_ALUWB:   cur <= S_FETCH;
                S_BRANCH:  cur <= S_FETCH;
                S_ADDIEX:  cur <= S_ADDIWB;
                S_ADDIWB:  cur <= S_FETCH;
                S_JUMP:    cur <= S_FETCH;
                default:   cur <= S_FETCH;
            endcase
        end
    end

    // Moore output decode; wait-state enables follow mem_ready, reset kills enables
    always_comb begin
        iord       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = ALU_ADD;
        pcsrc      = 2'b00;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        illegal_op = 1'b0;
`ifdef BNE_EN
        branch_ne  = 1'b0;
`endif
        case (cur)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ok;
                pcwrite = mem_ok;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                illegal_op = ~op_known;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = mem_ok;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALU_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALU_SUB;
                pcsrc   = 2'b01;
                branch  = ~is_bne;
`ifdef BNE_EN
                branch_ne = is_bne;
`endif
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            irwrite    = 1'b0;
            pcwrite    = 1'b0;
            branch     = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            illegal_op = 1'b0;
`ifdef BNE_EN
            branch_ne  = 1'b0;
`endif
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller (default build).
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       iord, alusrca, irwrite, pcwrite, branch, memwrite;
    logic       regwrite, regdst, memtoreg, illegal_op;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .aluop      (aluop),
        .pcsrc      (pcsrc),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .illegal_op (illegal_op),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: iord srca srcb[2] aluop[2] pcsrc[2] irw pcw br mw rw rd m2r ill state[4]
    localparam logic [19:0] MASK_ALL = 20'hFFFFF;
    localparam logic [19:0] MASK_EN  = 20'h00F90;

    typedef struct {
        logic        rst;
        logic [5:0]  opc;
        logic        mr;
        logic [19:0] mask;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [19:0] mk(input logic [3:0] st, input logic io, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] ao,
                                       input logic [1:0] ps, input logic irw, input logic pcw,
                                       input logic br, input logic mw, input logic rw,
                                       input logic rd, input logic m2r, input logic ill);
        return {io, sa, sb, ao, ps, irw, pcw, br, mw, rw, rd, m2r, ill, st};
    endfunction

    function automatic logic [19:0] actual();
        return {iord, alusrca, alusrcb, aluop, pcsrc, irwrite, pcwrite, branch,
                memwrite, regwrite, regdst, memtoreg, illegal_op, state};
    endfunction

    task automatic add(input logic rst, input logic [5:0] opc, input logic mr,
                       input logic [19:0] mask, input logic [19:0] exp);
        vec_t v;
        v.rst = rst; v.opc = opc; v.mr = mr; v.mask = mask; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    int rw_cnt;
    logic [3:0] lw_st[8];
    logic       lw_mr[8];

    initial begin
        reset = 1'b1; op = 6'b000000; mem_ready = 1'b1;

        // Reset: only enables are defined while reset is high
        add(1, 6'b000000, 1, MASK_EN, mk(0, 0,0,2'b00,2'b00,2'b00, 0,0,0,0,0,0,0,0));
        add(1, 6'b000000, 1, MASK_EN, mk(0, 0,0,2'b00,2'b00,2'b00, 0,0,0,0,0,0,0,0));
        // R-type: 0,1,6,7
        add(0, 6'b000000, 1, MASK_ALL, mk(0,  0,0,2'b01,2'b00,2'b00, 1,1,0,0,0,0,0,0));
        add(0, 6'b000000, 1, MASK_ALL, mk(1,  0,0,2'b11,2'b00,2'b00, 0,0,0,0,0,0,0,0));
        add(0, 6'b000000, 1, MASK_ALL, mk(6,  0,1,2'b00,2'b10,2'b00, 0,0,0,0,0,0,0,0));
        add(0, 6'b000000, 1, MASK_ALL, mk(7,  0,0,2'b00,2'b00,2'b00, 0,0,0,0,1,1,0,0));
        // beq: 0,1,8
        add(0, 6'b000100, 1, MASK_ALL, mk(0,  0,0,2'b01,2'b00,2'b00, 1,1,0,0,0,0,0,0));
        add(0, 6'b000100, 1, MASK_ALL, mk(1,  0,0,2'b11,2'b00,2'b00, 0,0,0,0,0,0,0,0));
        add(0, 6'b000100, 1, MASK_ALL, mk(8,  0,1,2'b00,2'b01,2'b01, 0,0,1,0,0,0,0,0));
        // j: 0,1,11
        add(0, 6'b000010, 1, MASK_ALL, mk(0,  0,0,2'b01,2'b00,2'b00, 1,1,0,0,0,0,0,0));
        add(0, 6'b000010, 1, MASK_ALL, mk(1,  0,0,2'b11,2'b00,2'b00, 0,0,0,0,0,0,0,0));
        add(0, 6'b000010, 1, MASK_ALL, mk(11, 0,0,2'b00,2'b00,2'b10, 0,1,0,0,0,0,0,0));
        // addi with one fetch wait: 0,0,1,9,10
        add(0, 6'b001000, 0, MASK_ALL, mk(0,  0,0,2'b01,2'b00,2'b00, 0,0,0,0,0,0,0,0));
        add(0, 6'b001000, 1, MASK_ALL, mk(0,  0,0,2'b01,2'b00,2'b00, 1,1,0,0,0,0,0,0));
        add(0, 6'b001000, 1, MASK_ALL, mk(1,  0,0,2'b11,2'b00,2'b00, 0,0,0,0,0,0,0,0));
        add(0, 6'b001000, 1, MASK_ALL, mk(9,  0,1,2'b10,2'b00,2'b00, 0,0,0,0,0,0,0,0));
        add(0, 6'b001000, 1, MASK_ALL, mk(10, 0,0,2'b00,2'b00,2'b00, 0,0,0,0,1,0,0,0));
        // sw with two wait cycles in MEMWR: memwrite only on the ready cycle
        add(0, 6'b101011, 1, MASK_ALL, mk(0,  0,0,2'b01,2'b00,2'b00, 1,1,0,0,0,0,0,0));
        add(0, 6'b101011, 1, MASK_ALL, mk(1,  0,0,2'b11,2'b00,2'b00, 0,0,0,0,0,0,0,0));
        add(0, 6'b101011, 1, MASK_ALL, mk(2,  0,1,2'b10,2'b00,2'b00, 0,0,0,0,0,0,0,0));
        add(0, 6'b101011, 0, MASK_ALL, mk(5,  1,0,2'b00,2'b00,2'b00, 0,0,0,0,0,0,0,0));
        add(0, 6'b101011, 0, MASK_ALL, mk(5,  1,0,2'b00,2'b00,2'b00, 0,0,0,0,0,0,0,0));
        add(0, 6'b101011, 1, MASK_ALL, mk(5,  1,0,2'b00,2'b00,2'b00, 0,0,0,1,0,0,0,0));

        // Table application: drive away from the edge, compare, then clock
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; op = vecs[i].opc; mem_ready = vecs[i].mr;
            #1;
            chk($sformatf("vec%0d", i), 32'(actual() & vecs[i].mask),
                32'(vecs[i].exp & vecs[i].mask));
            next_cycle();
        end

        // lw with three MEMRD wait cycles: 8 cycles, one regwrite with memtoreg
        lw_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        lw_mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        rw_cnt = 0;
        op = 6'b100011;
        for (int c = 0; c < 8; c++) begin
            mem_ready = lw_mr[c];
            #1;
            chk($sformatf("lw_state%0d", c), 32'(state), 32'(lw_st[c]));
            if (regwrite) begin
                rw_cnt++;
                chk("lw_memtoreg", 32'(memtoreg), 32'd1);
                chk("lw_wb_state", 32'(state), 32'd4);
            end
            next_cycle();
        end
        chk("lw_regwrite_count", 32'(rw_cnt), 32'd1);
        chk("lw_done_state", 32'(state), 32'd0);

        // Illegal opcodes (000001 and, in the default build, 000101)
        foreach (lw_mr[k]) lw_mr[k] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            op = (t == 0) ? 6'b000001 : 6'b000101;
            mem_ready = 1'b1;
            #1;
            chk($sformatf("ill%0d_fetch", t), 32'(state), 32'd0);
            next_cycle();
            #1;
            chk($sformatf("ill%0d_decode_state", t), 32'(state), 32'd1);
            chk($sformatf("ill%0d_pulse", t), 32'(illegal_op), 32'd1);
            chk($sformatf("ill%0d_writes", t), 32'({regwrite, memwrite}), 32'd0);
            next_cycle();
            #1;
            chk($sformatf("ill%0d_back_fetch", t), 32'(state), 32'd0);
            chk($sformatf("ill%0d_pulse_gone", t), 32'(illegal_op), 32'd0);
            chk($sformatf("ill%0d_writes2", t), 32'({regwrite, memwrite}), 32'd0);
        end

        // Reset asserted while waiting in MEMRD
        op = 6'b100011; mem_ready = 1'b1;
        next_cycle(); next_cycle(); next_cycle();
        reset = 1'b1;
        #1;
        chk("rst_mid_state", 32'(state), 32'd3);
        chk("rst_mid_enables",
            32'({irwrite, pcwrite, branch, memwrite, regwrite, illegal_op}), 32'd0);
        next_cycle();
        reset = 1'b0;
        #1;
        chk("rst_mid_fetch", 32'(state), 32'd0);
        chk("rst_mid_fetch_en", 32'({irwrite, pcwrite}), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so a broken design cannot hang the run
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
